// File: rtl/rle_dec_param.sv
// Run-length decoder: expands {symbol, count, last} run words into a stream of
// {symbol, last} words, one per cycle, with a single registered output stage.
module rle_dec_param #(
  parameter int unsigned SYMBOL_WIDTH = 1,
  parameter int unsigned COUNT_WIDTH  = 4,
  parameter int unsigned ZERO_MODE    = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [SYMBOL_WIDTH+COUNT_WIDTH+1-1:0]  in_data,
  input  logic                                   in_vld,
  output logic                                   in_rdy,
  output logic [SYMBOL_WIDTH+1-1:0]              out_data,
  output logic                                   out_vld,
  input  logic                                   out_rdy,
  output logic                                   busy
);

  localparam int unsigned IN_W  = SYMBOL_WIDTH + COUNT_WIDTH + 1;
  localparam int unsigned OUT_W = SYMBOL_WIDTH + 1;
  localparam int unsigned REM_W = COUNT_WIDTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [REM_W-1:0]         rem_q, rem_d;
  logic [SYMBOL_WIDTH-1:0]  sym_q, sym_d;
  logic                     last_q, last_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     out_vld_q, out_vld_d;

  logic [SYMBOL_WIDTH-1:0]  in_sym;
  logic [COUNT_WIDTH-1:0]   in_count;
  logic                     in_last;
  logic [REM_W-1:0]         in_n_m1;
  logic                     out_free;
  logic                     in_fire;

  assign in_sym   = in_data[IN_W-1 -: SYMBOL_WIDTH];
  assign in_count = in_data[COUNT_WIDTH:1];
  assign in_last  = in_data[0];

  // Symbols of the captured run still to be loaded after the first one.
  always_comb begin
    in_n_m1 = '0;
    if (in_count == '0) begin
      if (ZERO_MODE != 0) in_n_m1 = {1'b0, {COUNT_WIDTH{1'b1}}};
    end else begin
      in_n_m1 = REM_W'(in_count) - REM_W'(1);
    end
  end

  assign out_free = !out_vld_q || out_rdy;
  assign in_rdy   = !reset && (rem_q == '0) && out_free;
  assign in_fire  = in_vld && in_rdy;

  assign out_data = out_data_q;
  assign out_vld  = out_vld_q;
  assign busy     = (rem_q != '0) || out_vld_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      sym_q      <= '0;
      last_q     <= 1'b0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      sym_q      <= sym_d;
      last_q     <= last_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
    end
  end

  // The input transfer loads the first symbol directly, so runs chain without bubbles.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    sym_d      = sym_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;

    if (out_free) out_vld_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          sym_d      = in_sym;
          last_d     = in_last;
          rem_d      = in_n_m1;
          out_data_d = {in_sym, in_last && (in_n_m1 == '0)};
          out_vld_d  = 1'b1;
          if (in_n_m1 != '0) state_d = RUN;
        end
      end
      RUN: begin
        if (out_free && (rem_q != '0)) begin
          rem_d      = rem_q - REM_W'(1);
          out_data_d = {sym_q, last_q && (rem_q == REM_W'(1))};
          out_vld_d  = 1'b1;
          if (rem_q == REM_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rle_dec_param.sv
// Directed and random checks of rle_dec_param (8-bit symbols, 4-bit counts),
// with one instance per ZERO_MODE sharing the stimulus through a select.
module tb_rle_dec_param;

  localparam int unsigned SW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [12:0]   in_data;
  logic          in_vld;
  logic          out_rdy;
  logic          sel;

  logic          in_vld0, in_vld1, in_rdy0, in_rdy1, out_vld0, out_vld1, busy0, busy1;
  logic [8:0]    out_data0, out_data1;
  logic          i_rdy, o_vld, bsy;
  logic [8:0]    o_data;

  always #5 clk = ~clk;

  assign in_vld0 = in_vld && !sel;
  assign in_vld1 = in_vld && sel;
  assign i_rdy   = sel ? in_rdy1 : in_rdy0;
  assign o_vld   = sel ? out_vld1 : out_vld0;
  assign o_data  = sel ? out_data1 : out_data0;
  assign bsy     = sel ? busy1 : busy0;

  rle_dec_param #(.SYMBOL_WIDTH(SW), .COUNT_WIDTH(CW), .ZERO_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_vld(in_vld0), .in_rdy(in_rdy0),
    .out_data(out_data0), .out_vld(out_vld0), .out_rdy(out_rdy), .busy(busy0));

  rle_dec_param #(.SYMBOL_WIDTH(SW), .COUNT_WIDTH(CW), .ZERO_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_vld(in_vld1), .in_rdy(in_rdy1),
    .out_data(out_data1), .out_vld(out_vld1), .out_rdy(out_rdy), .busy(busy1));

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc_n = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  obs_q[$];
  int          obs_cyc[$];
  int          exp_base = 0;
  int          obs_base = 0;
  int          stab_n = 0;
  int          stab_err = 0;
  logic        stall_p = 1'b0;
  logic [8:0]  held = '0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Output monitor: collects transferred words and watches stalled words for stability.
  always @(negedge clk) begin
    if (stall_p) begin
      stab_n++;
      if (!o_vld || o_data !== held) stab_err++;
    end
    stall_p = o_vld && !out_rdy && !reset;
    held    = o_data;
    if (o_vld && out_rdy) begin
      obs_q.push_back(o_data);
      obs_cyc.push_back(cyc_n);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expand(input logic [7:0] sym, input logic [3:0] cnt, input logic last,
                        input logic zm);
    int n;
    n = (cnt == 4'd0) ? (zm ? 16 : 1) : int'(cnt);
    for (int i = 0; i < n; i++) exp_q.push_back({sym, last && (i == n - 1)});
  endtask

  // Present one run word and hold it until accepted; returns in the cycle after transfer.
  task automatic send(input logic [7:0] sym, input logic [3:0] cnt, input logic last);
    bit done;
    done    = 0;
    in_data = {sym, cnt, last};
    in_vld  = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (i_rdy) done = 1;
      cyc();
    end
    in_vld = 1'b0;
    if (done) expand(sym, cnt, last, sel);
    else chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done;
    done    = 0;
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!bsy) done = 1;
      else cyc();
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
    cyc();
  endtask

  task automatic cmp_stream(input string tag);
    int no, ne;
    no = obs_q.size() - obs_base;
    ne = exp_q.size() - exp_base;
    chk({tag, "_len"}, 32'(no), 32'(ne));
    for (int i = 0; i < no && i < ne; i++)
      chk(tag, 32'(obs_q[obs_base + i]), 32'(exp_q[exp_base + i]));
    obs_base = obs_q.size();
    exp_base = exp_q.size();
  endtask

  initial begin
    logic [6:0] pat;
    logic [7:0] r_sym;
    logic [3:0] r_cnt;
    logic       r_last;
    bit         pending;
    int         guard;

    reset   = 1'b1;
    in_vld  = 1'b0;
    in_data = '0;
    out_rdy = 1'b0;
    sel     = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_in_rdy0", 32'(in_rdy0), 32'd0);
    chk("rst_in_rdy1", 32'(in_rdy1), 32'd0);
    chk("rst_out_vld", 32'(out_vld0), 32'd0);
    chk("rst_out_data", 32'(out_data0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_rdy_rise", 32'(i_rdy), 32'd1);

    // Single run: latency 1, in_rdy low until final symbol is presented.
    out_rdy = 1'b1;
    send(8'hA5, 4'd3, 1'b1);
    @(negedge clk);
    chk("t1_vld", 32'(o_vld), 32'd1);
    chk("t1_w1", 32'(o_data), 32'h14A);
    chk("t1_rdy1", 32'(i_rdy), 32'd0);
    chk("t1_busy", 32'(bsy), 32'd1);
    cyc();
    @(negedge clk);
    chk("t1_w2", 32'(o_data), 32'h14A);
    chk("t1_rdy2", 32'(i_rdy), 32'd0);
    cyc();
    @(negedge clk);
    chk("t1_w3", 32'(o_data), 32'h14B);
    chk("t1_rdy3", 32'(i_rdy), 32'd1);
    drain();
    cmp_stream("t1");

    // Back-to-back runs with no bubble.
    send(8'h11, 4'd2, 1'b0);
    send(8'h22, 4'd1, 1'b1);
    drain();
    chk("t2_nobubble", 32'(obs_cyc[obs_q.size() - 1] - obs_cyc[obs_base]), 32'd2);
    cmp_stream("t2");

    // Count boundaries on both zero modes.
    send(8'h77, 4'd0, 1'b1);
    drain();
    cmp_stream("zm0_cnt0");
    send(8'hE1, 4'd15, 1'b1);
    drain();
    cmp_stream("zm0_cnt15");
    sel = 1'b1;
    #1;
    send(8'h66, 4'd0, 1'b1);
    drain();
    cmp_stream("zm1_cnt0");
    send(8'h55, 4'd3, 1'b0);
    drain();
    cmp_stream("zm1_cnt3");
    sel = 1'b0;
    #1;

    // Backpressure pattern 1,0,0,1,0,1,1 starting with the first output cycle.
    pat = 7'b1001011;
    send(8'h3C, 4'd4, 1'b1);
    for (int k = 6; k >= 0; k--) begin
      out_rdy = pat[k];
      cyc();
    end
    drain();
    cmp_stream("stall");

    // Reset after 2 of 5 symbols discards the rest of the run.
    out_rdy = 1'b1;
    send(8'h5A, 4'd5, 1'b1);
    cyc();
    reset = 1'b1;
    cyc();
    @(negedge clk);
    chk("mr_out_vld", 32'(o_vld), 32'd0);
    chk("mr_busy", 32'(bsy), 32'd0);
    chk("mr_in_rdy", 32'(i_rdy), 32'd0);
    chk("mr_out_data", 32'(o_data), 32'd0);
    cyc();
    reset = 1'b0;
    repeat (8) cyc();
    repeat (3) void'(exp_q.pop_back());
    cmp_stream("midrst");

    // Random runs with random handshakes against the reference expansion.
    pending = 0;
    guard   = 0;
    while ((exp_q.size() - exp_base) < 10000 && guard < 60000) begin
      if (!pending) begin
        r_sym   = 8'($urandom);
        r_cnt   = 4'($urandom_range(0, 15));
        r_last  = 1'($urandom_range(0, 1));
        pending = 1;
      end
      in_data = {r_sym, r_cnt, r_last};
      in_vld  = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_vld && i_rdy) begin
        expand(r_sym, r_cnt, r_last, sel);
        pending = 0;
      end
      cyc();
      guard++;
    end
    drain();
    cmp_stream("rnd");
    chk("stall_stable", 32'(stab_err), 32'd0);
    chk("stall_seen", 32'(stab_n != 0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
